// File: rtl/conv_seq_pkg.sv
// Shared types and elaboration helpers for the 1-D convolution sequencer.
package conv_seq_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_e;

  function automatic int clog2_min1(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  function automatic int op_count(input int x_count, input int f_count, input int stride);
    return (x_count - f_count) / stride + 1;
  endfunction

endpackage

// File: rtl/conv_seq_if.sv
// Load, datapath-control and output handshake bundle between the sequencer and the MAC datapath.
interface conv_seq_if #(
  parameter int ADDR_X = 4,
  parameter int ADDR_F = 2,
  parameter int CNT_O  = 4
);
  logic              s_valid_x;
  logic              s_ready_x;
  logic              wr_en_x;
  logic [ADDR_X-1:0] addr_x;
  logic [ADDR_F-1:0] addr_f;
  logic              en_acc;
  logic              clear_acc;
  logic              m_valid_y;
  logic              m_ready_y;
  logic [CNT_O-1:0]  out_idx;
  logic              frame_done;

  modport master (
    input  s_valid_x, m_ready_y,
    output s_ready_x, wr_en_x, addr_x, addr_f, en_acc, clear_acc,
           m_valid_y, out_idx, frame_done
  );

  modport slave (
    output s_valid_x, m_ready_y,
    input  s_ready_x, wr_en_x, addr_x, addr_f, en_acc, clear_acc,
           m_valid_y, out_idx, frame_done
  );
endinterface

// File: rtl/conv_seq_vpipe.sv
// Valid shift register that delays the issue strobe to line up with the product at the MAC input.
module conv_seq_vpipe #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic out
);
  logic [DEPTH-1:0] sr;

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every stage samples its pre-edge neighbour.
    if (reset) sr <= '0;
    else       sr <= DEPTH'({sr, in});
  end

  assign out = sr[DEPTH-1];
endmodule

// File: rtl/conv_seq_ctrl.sv
// Sequencer for the single-MAC convolution: loads X, issues F_COUNT taps per output, drains the pipe, hands off y.
module conv_seq_ctrl
  import conv_seq_pkg::*;
#(
  parameter int X_COUNT  = 16,
  parameter int F_COUNT  = 4,
  parameter int STRIDE   = 1,
  parameter int PIPE_LAT = 2
) (
  input logic        clk,
  input logic        reset,
  conv_seq_if.master bus
);
  localparam int ADDR_X   = clog2_min1(X_COUNT);
  localparam int ADDR_F   = clog2_min1(F_COUNT);
  localparam int OP_COUNT = op_count(X_COUNT, F_COUNT, STRIDE);
  localparam int CNT_O    = $clog2(OP_COUNT + 1);
  localparam int CNT_D    = clog2_min1(PIPE_LAT);

  localparam logic [1:0] ST_LOAD  = LOAD;
  localparam logic [1:0] ST_ISSUE = ISSUE;
  localparam logic [1:0] ST_DRAIN = DRAIN;
  localparam logic [1:0] ST_OUT   = OUT;

  localparam logic [ADDR_X-1:0] LAST_X = ADDR_X'(X_COUNT - 1);
  localparam logic [ADDR_X-1:0] STEP   = ADDR_X'(STRIDE);
  localparam logic [ADDR_F-1:0] LAST_F = ADDR_F'(F_COUNT - 1);
  localparam logic [CNT_D-1:0]  LAST_D = CNT_D'(PIPE_LAT - 1);
  localparam logic [CNT_O-1:0]  LAST_O = CNT_O'(OP_COUNT - 1);

  if (F_COUNT < 1)                         begin : g_bad_f      $fatal(1, "F_COUNT must be >= 1"); end
  if (X_COUNT < F_COUNT)                   begin : g_bad_x      $fatal(1, "X_COUNT must be >= F_COUNT"); end
  if ((X_COUNT - F_COUNT) % STRIDE != 0)   begin : g_bad_stride $fatal(1, "STRIDE must divide X_COUNT-F_COUNT"); end
  if (PIPE_LAT < 1)                        begin : g_bad_lat    $fatal(1, "PIPE_LAT must be >= 1"); end

  logic [1:0]        state;
  logic [ADDR_X-1:0] wr_ptr;
  logic [ADDR_X-1:0] base;
  logic [ADDR_F-1:0] tap;
  logic [CNT_D-1:0]  drain_cnt;
  logic [CNT_O-1:0]  out_idx;
  logic              issue;
  logic              last_out;

  assign issue    = (state == ST_ISSUE);
  assign last_out = (out_idx == LAST_O);

  conv_seq_vpipe #(.DEPTH(PIPE_LAT)) u_vpipe (
    .clk   (clk),
    .reset (reset),
    .in    (issue),
    .out   (bus.en_acc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_LOAD;
      wr_ptr    <= '0;
      base      <= '0;
      tap       <= '0;
      drain_cnt <= '0;
      out_idx   <= '0;
    end else begin
      case (state)
        ST_LOAD: if (bus.s_valid_x) begin
          if (wr_ptr == LAST_X) begin
            wr_ptr  <= '0;
            base    <= '0;
            tap     <= '0;
            out_idx <= '0;
            state   <= ST_ISSUE;
          end else begin
            wr_ptr <= wr_ptr + 1'b1;
          end
        end
        ST_ISSUE: if (tap == LAST_F) begin
          tap       <= '0;
          drain_cnt <= '0;
          state     <= ST_DRAIN;
        end else begin
          tap <= tap + 1'b1;
        end
        // The last product lands in the accumulator on the same edge that enters OUT.
        ST_DRAIN: if (drain_cnt == LAST_D) state <= ST_OUT;
                  else                     drain_cnt <= drain_cnt + 1'b1;
        ST_OUT: if (bus.m_ready_y) begin
          if (last_out) begin
            out_idx <= '0;
            base    <= '0;
            state   <= ST_LOAD;
          end else begin
            out_idx <= out_idx + 1'b1;
            base    <= base + STEP;
            state   <= ST_ISSUE;
          end
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

  always_comb begin
    // NOTE: every output is assigned on every path, so no latch can be inferred.
    bus.s_ready_x  = (state == ST_LOAD);
    bus.wr_en_x    = !reset && (state == ST_LOAD) && bus.s_valid_x;
    bus.addr_x     = (state == ST_LOAD) ? wr_ptr : base + ADDR_X'(tap);
    bus.addr_f     = tap;
    bus.m_valid_y  = (state == ST_OUT);
    bus.clear_acc  = reset || ((state == ST_OUT) && bus.m_ready_y);
    bus.frame_done = !reset && (state == ST_OUT) && bus.m_ready_y && last_out;
    bus.out_idx    = out_idx;
  end
endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Directed bench: stride-1 controller with a behavioural MAC datapath, plus a stride-2 instance sharing the stimulus.
module tb_conv_seq_ctrl;
  import conv_seq_pkg::*;

  localparam int XC  = 16;
  localparam int FC  = 4;
  localparam int PL  = 2;
  localparam int OP1 = op_count(XC, FC, 1);
  localparam int OP2 = op_count(XC, FC, 2);
  localparam int AX  = clog2_min1(XC);
  localparam int AF  = clog2_min1(FC);
  localparam int CO1 = $clog2(OP1 + 1);
  localparam int CO2 = $clog2(OP2 + 1);

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  conv_seq_if #(.ADDR_X(AX), .ADDR_F(AF), .CNT_O(CO1)) bus ();
  conv_seq_if #(.ADDR_X(AX), .ADDR_F(AF), .CNT_O(CO2)) bus2 ();

  assign bus2.s_valid_x = bus.s_valid_x;
  assign bus2.m_ready_y = bus.m_ready_y;

  conv_seq_ctrl #(.X_COUNT(XC), .F_COUNT(FC), .STRIDE(1), .PIPE_LAT(PL)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  conv_seq_ctrl #(.X_COUNT(XC), .F_COUNT(FC), .STRIDE(2), .PIPE_LAT(PL)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Behavioural datapath: X memory, filter ROM, 1-cycle read, registered multiply, accumulator.
  function automatic int coef(input int j);
    case (j)
      0: return 767;
      1: return 459;
      2: return -46;
      default: return -608;
    endcase
  endfunction

  int xmem [XC];
  int xref [XC];
  int x_data = 0;
  int x_rd = 0, f_rd = 0, prod = 0, acc = 0;

  always @(posedge clk) begin
    if (bus.wr_en_x) xmem[bus.addr_x] <= x_data;
    x_rd <= xmem[bus.addr_x];
    f_rd <= coef(int'(bus.addr_f));
    prod <= x_rd * f_rd;
    if (bus.clear_acc)   acc <= 0;
    else if (bus.en_acc) acc <= acc + prod;
  end

  function automatic int exp_y(input int k);
    int s;
    s = 0;
    for (int j = 0; j < FC; j++) s += coef(j) * xref[k + j];
    return (s < 0) ? 0 : s;
  endfunction

  // Monitor state, sampled on the falling edge.
  int k1 = 0, j1 = 0, last_wr = 0, last_hs = 0, wr_cnt = 0, y_first = 0, y_last = 0;
  int hx1 = 0, hx2 = 0, hf1 = 0, hf2 = 0;
  int k2 = 0, j2 = 0, gx1 = 0, gx2 = 0, gf1 = 0, gf2 = 0, frames2 = 0;
  bit mv_prev = 1'b0;
  bit period_on = 1'b0;

  task automatic monitor();
    int y;
    cyc++;
    y = (acc < 0) ? 0 : acc;
    if (reset) begin
      k1 = 0; j1 = 0; k2 = 0; j2 = 0;
    end else begin
      if (bus.wr_en_x) begin
        check("wr_addr", int'(bus.addr_x), wr_cnt);
        wr_cnt++;
        last_wr = cyc;
      end
      if (bus.en_acc) begin
        if (k1 == 0 && j1 == 0) check("en_latency", cyc - last_wr, 3);
        check("issue_addr_f", hf2, j1);
        check("issue_addr_x", hx2, k1 + j1);
        j1++;
      end
      if (bus.m_valid_y) begin
        check("en_during_out", int'(bus.en_acc), 0);
        if (!mv_prev && k1 == 0) check("out_latency", cyc - last_wr, 7);
        if (bus.m_ready_y) begin
          check("burst_len", j1, FC);
          check("out_idx", int'(bus.out_idx), k1);
          check("y_value", y, exp_y(k1));
          if (period_on && k1 > 0) check("out_period", cyc - last_hs, 7);
          if (k1 == 0) y_first = y;
          y_last  = y;
          last_hs = cyc;
          k1++;
          j1 = 0;
          check("frame_done", int'(bus.frame_done), int'(k1 == OP1));
          if (bus.frame_done) k1 = 0;
        end
      end
      if (bus2.en_acc) begin
        check("s2_addr_f", gf2, j2);
        check("s2_addr_x", gx2, 2 * k2 + j2);
        j2++;
      end
      if (bus2.m_valid_y && bus2.m_ready_y) begin
        check("s2_burst_len", j2, FC);
        check("s2_out_idx", int'(bus2.out_idx), k2);
        k2++;
        j2 = 0;
        check("s2_frame_done", int'(bus2.frame_done), int'(k2 == OP2));
        if (bus2.frame_done) begin
          k2 = 0;
          frames2++;
        end
      end
    end
    hx2 = hx1; hx1 = int'(bus.addr_x);
    hf2 = hf1; hf1 = int'(bus.addr_f);
    gx2 = gx1; gx1 = int'(bus2.addr_x);
    gf2 = gf1; gf1 = int'(bus2.addr_f);
    mv_prev = bus.m_valid_y;
  endtask

  initial forever begin
    @(negedge clk);
    monitor();
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mode 0: ramp 1..16, mode 1: all ones, mode 2: descending 16..1
  task automatic load(input int mode, input bit toggle);
    int v;
    wr_cnt = 0;
    for (int i = 0; i < XC; i++) begin
      v = (mode == 0) ? i + 1 : (mode == 1) ? 1 : XC - i;
      xref[i] = v;
      x_data = v;
      bus.s_valid_x = 1'b1;
      step();
      if (i == XC - 1) check("ready_drop_after_load", int'(bus.s_ready_x), 0);
      if (toggle) begin
        bus.s_valid_x = 1'b0;
        step();
      end
    end
    bus.s_valid_x = 1'b0;
    check("wr_count", wr_cnt, XC);
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 400 && !seen; n++) begin
      step();
      seen = bus.frame_done;
    end
    check("frame_done_seen", int'(seen), 1);
    step();
    check("ready_after_frame", int'(bus.s_ready_x), 1);
  endtask

  task automatic wait_idx(input int target);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 400 && !seen; n++) begin
      step();
      seen = (int'(bus.out_idx) == target);
    end
    check("out_idx_reached", int'(seen), 1);
  endtask

  initial begin
    int ax, af;
    bit seen;
    bus.s_valid_x = 1'b1;
    bus.m_ready_y = 1'b1;
    repeat (2) step();
    check("rst_clear_acc", int'(bus.clear_acc), 1);
    check("rst_wr_en", int'(bus.wr_en_x), 0);
    check("rst_en_acc", int'(bus.en_acc), 0);
    check("rst_m_valid", int'(bus.m_valid_y), 0);
    check("rst_frame_done", int'(bus.frame_done), 0);
    check("rst_out_idx", int'(bus.out_idx), 0);
    reset = 1'b0;
    bus.s_valid_x = 1'b0;
    #1;
    check("ready_after_reset", int'(bus.s_ready_x), 1);
    check("no_clear_idle", int'(bus.clear_acc), 0);

    // Frame A: ramp input, gapped load, free-running output.
    period_on = 1'b1;
    load(0, 1'b1);
    wait_done();
    check("frameA_y0", y_first, 0);
    check("frameA_y12", y_last, 5979);

    // Frame B: all-ones input, backpressure on output 5.
    period_on = 1'b0;
    load(1, 1'b0);
    wait_idx(5);
    bus.m_ready_y = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      seen = bus.m_valid_y;
      if (!seen) step();
    end
    check("bp_valid_reached", int'(seen), 1);
    ax = int'(bus.addr_x);
    af = int'(bus.addr_f);
    for (int i = 0; i < 10; i++) begin
      check("bp_valid_held", int'(bus.m_valid_y), 1);
      check("bp_out_idx", int'(bus.out_idx), 5);
      check("bp_addr_x", int'(bus.addr_x), ax);
      check("bp_addr_f", int'(bus.addr_f), af);
      check("bp_en_acc", int'(bus.en_acc), 0);
      check("bp_clear_acc", int'(bus.clear_acc), 0);
      step();
    end
    bus.m_ready_y = 1'b1;
    #1;
    check("release_clear", int'(bus.clear_acc), 1);
    step();
    check("release_single_clear", int'(bus.clear_acc), 0);
    check("release_valid_drop", int'(bus.m_valid_y), 0);
    wait_done();
    check("frameB_y0", y_first, 572);
    check("frameB_y12", y_last, 572);

    // Frame C: aborted by reset in the middle of issuing output 3.
    load(0, 1'b0);
    wait_idx(3);
    step();
    reset = 1'b1;
    #1;
    check("midrst_clear_acc", int'(bus.clear_acc), 1);
    check("midrst_wr_en", int'(bus.wr_en_x), 0);
    step();
    reset = 1'b0;
    #1;
    check("midrst_ready", int'(bus.s_ready_x), 1);
    check("midrst_en_acc", int'(bus.en_acc), 0);
    check("midrst_m_valid", int'(bus.m_valid_y), 0);
    check("midrst_out_idx", int'(bus.out_idx), 0);

    // Frame D: fresh descending frame after the abort.
    period_on = 1'b1;
    load(2, 1'b0);
    wait_done();
    check("frameD_y0", y_first, 10609);
    check("stride2_frames", frames2, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
